// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor sequencing one external 4-bit ripple slice,
// one nibble per cycle LSB first, with valid/ready handshakes on both sides.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q, overflow_d;
  logic              out_valid_q, out_valid_d;
  logic [IDXW+1:0]   nib_base;

  assign nib_base = {idx_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    add_a       = '0;
    add_b       = '0;
    add_cin     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is folded in here: B is stored inverted with carry-in forced to 1.
          a_d      = op_a;
          b_d      = sub ? ~op_b : op_b;
          carry_d  = sub | op_cin;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[nib_base +: 4];
        add_b   = b_q[nib_base +: 4];
        add_cin = carry_q;
        result_d[nib_base +: 4] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          carry_out_d = add_cout;
          overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: an ideal 4-bit adder closes the loop, a
// transaction-level model checks outputs every cycle, literal vectors pin the model.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1..4 working on nibble phase-1, 5 holding a result.
  int          phase = 0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic        m_c0 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
    end else if (phase == 0) begin
      if (in_valid) begin
        m_a   <= op_a;
        m_b   <= sub ? ~op_b : op_b;
        m_c0  <= sub | op_cin;
        phase <= 1;
      end
    end else if (phase < 5) begin
      phase <= phase + 1;
    end else if (out_ready) begin
      phase <= 0;
    end
  end

  function automatic logic carry_into(input int k);
    logic [31:0] mask;
    logic [31:0] part;
    mask = (32'd1 << (4 * k)) - 32'd1;
    part = (32'(m_a) & mask) + (32'(m_b) & mask) + 32'(m_c0);
    return part[4 * k];
  endfunction

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [16:0] full;
      full = {1'b0, m_a} + {1'b0, m_b} + 17'(m_c0);
      check("in_ready", 32'(in_ready), 32'(phase == 0));
      check("out_valid", 32'(out_valid), 32'(phase == 5));
      if (phase >= 1 && phase <= 4) begin
        check("add_a", 32'(add_a), 32'(m_a[4 * (phase - 1) +: 4]));
        check("add_b", 32'(add_b), 32'(m_b[4 * (phase - 1) +: 4]));
        check("add_cin", 32'(add_cin), 32'(carry_into(phase - 1)));
      end else begin
        check("add_idle", {23'd0, add_a, add_b, add_cin}, 32'd0);
      end
      if (phase == 5) begin
        check("m_result", 32'(result), 32'(full[15:0]));
        check("m_carry", 32'(carry_out), 32'(full[16]));
        check("m_ovf", 32'(overflow),
              32'((m_a[15] == m_b[15]) && (full[15] != m_a[15])));
      end
    end
  end

  logic [3:0] cap_a   [4];
  logic       cap_cin [4];

  // Leaves the caller at the negedge where out_valid is first seen high.
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic s, input logic [15:0] exp_r,
                       input logic exp_co, input logic exp_ov);
    int lat;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    op_a = a; op_b = b; op_cin = ci; sub = s; in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        in_valid = 1'b0; op_a = ~a; op_b = ~b; op_cin = ~ci; sub = ~s;
      end
      lat++;
      if (lat <= 4) begin
        cap_a[lat - 1]   = add_a;
        cap_cin[lat - 1] = add_cin;
      end
    end while (!out_valid && lat < 20);
    check({name, "_latency"}, 32'(lat - 1), 32'd4);
    check({name, "_result"}, 32'(result), 32'(exp_r));
    check({name, "_carry"}, 32'(carry_out), 32'(exp_co));
    check({name, "_ovf"}, 32'(overflow), 32'(exp_ov));
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("released_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
    sub = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, carry_out, overflow, out_valid}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    do_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    check("t1_add_a", {16'd0, cap_a[0], cap_a[1], cap_a[2], cap_a[3]}, 32'h4321);
    release_op();

    do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("t2_add_cin", {28'd0, cap_cin[0], cap_cin[1], cap_cin[2], cap_cin[3]}, 32'b0111);
    release_op();

    do_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    release_op();
    do_op("t3b", 16'h1000, 16'h0FFF, 1'b1, 1'b0, 16'h2000, 1'b0, 1'b0);
    release_op();

    do_op("t4a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    release_op();
    do_op("t4b", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    release_op();

    do_op("t5", 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);
    in_valid = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; op_cin = 1'b1; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_hold_result", 32'(result), 32'h0406);
      check("t5_hold_ready", {30'd0, in_ready, out_valid}, 32'b01);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("t5_back_idle", {30'd0, in_ready, out_valid}, 32'b10);
    do_op("t5_next", 16'h0011, 16'h0022, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b0);
    release_op();

    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'h0001; op_cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_result", 32'(result), 32'd0);
    check("t6_rst_flags", {29'd0, carry_out, overflow, out_valid}, 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check("t6_rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_valid", 32'(out_valid), 32'd0);
    end
    do_op("t6_after", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    release_op();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
